// File: rtl/gain_requant_pipe.sv
// Two-stage valid/ready gain-and-requantize pipeline: per-lane signed multiply by a loadable
// Q-format gain, rescale with truncate or round-half-away rounding, saturate. Optional: SAT_COUNT_EN.
module gain_requant_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int GAIN_WIDTH   = 32,
   parameter int FRAC_BITS    = 10,
   parameter int OUT_WIDTH    = 32,
   parameter int CHANNELS     = 2,
   parameter int ROUND_MODE   = 0,
   parameter int DEFAULT_GAIN = 1024,
   localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           gain_wr_en,
   input  logic [CH_W-1:0]                gain_wr_ch,
   input  logic [GAIN_WIDTH-1:0]          gain_wr_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CHANNELS*OUT_WIDTH-1:0]  out_data,
   output logic [CHANNELS-1:0]            sat_flag,
   input  logic                           sat_clear
`ifdef SAT_COUNT_EN
   ,
   output logic [CHANNELS*16-1:0]         sat_count
`endif
);

   localparam int PW = DATA_WIDTH + GAIN_WIDTH;
   localparam int EW = PW + 1;
   localparam logic signed [EW-1:0] ONE        = {{(EW-1){1'b0}}, 1'b1};
   localparam logic signed [EW-1:0] OUT_MAX    = (ONE <<< (OUT_WIDTH - 1)) - ONE;
   localparam logic signed [EW-1:0] OUT_MIN    = -(ONE <<< (OUT_WIDTH - 1));
   localparam logic signed [EW-1:0] TRUNC_BIAS = (ONE <<< FRAC_BITS) - ONE;
   localparam logic signed [EW-1:0] ROUND_BIAS = ONE <<< (FRAC_BITS - 1);
   localparam logic signed [GAIN_WIDTH-1:0] GAIN_RST = GAIN_WIDTH'(DEFAULT_GAIN);
   localparam logic [31:0] CHANNELS_U = 32'(CHANNELS);

   function automatic logic signed [PW-1:0] mul_ext(input logic signed [DATA_WIDTH-1:0] d,
                                                    input logic signed [GAIN_WIDTH-1:0] g);
      logic signed [PW-1:0] de;
      logic signed [PW-1:0] ge;
      de = {{GAIN_WIDTH{d[DATA_WIDTH-1]}}, d};
      ge = {{DATA_WIDTH{g[GAIN_WIDTH-1]}}, g};
      mul_ext = de * ge;
   endfunction

   // One extra bit of headroom so negating the magnitude can never wrap.
   function automatic logic signed [EW-1:0] rescale(input logic signed [PW-1:0] prod);
      logic signed [EW-1:0] ext;
      logic signed [EW-1:0] mag;
      logic signed [EW-1:0] shifted;
      ext = {prod[PW-1], prod};
      mag = '0;
      shifted = '0;
      if (ROUND_MODE == 1) begin
         mag     = ext[EW-1] ? -ext : ext;
         shifted = (mag + ROUND_BIAS) >>> FRAC_BITS;
         rescale = ext[EW-1] ? -shifted : shifted;
      end else if (ext[EW-1]) begin
         rescale = (ext + TRUNC_BIAS) >>> FRAC_BITS;
      end else begin
         rescale = ext >>> FRAC_BITS;
      end
   endfunction

   logic signed [GAIN_WIDTH-1:0] gain_q [CHANNELS];
   logic signed [GAIN_WIDTH-1:0] gain_d [CHANNELS];
   logic signed [PW-1:0]         s1_prod_q [CHANNELS];
   logic signed [PW-1:0]         s1_prod_d [CHANNELS];
   logic                         s1_valid_q, s1_valid_d;
   logic                         out_valid_q, out_valid_d;
   logic [CHANNELS*OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [CHANNELS-1:0]          sat_flag_q, sat_flag_d;

   logic signed [EW-1:0]          scaled_s [CHANNELS];
   logic [CHANNELS*OUT_WIDTH-1:0] clamp_data_s;
   logic [CHANNELS-1:0]           clamp_sat_s;
   logic [CHANNELS-1:0]           sat_set_s;
   logic                          s2_load_s, in_ready_s, in_fire_s;

`ifdef SAT_COUNT_EN
   localparam logic [15:0] CNT_MAX = 16'hFFFF;
   logic [15:0] sat_cnt_q [CHANNELS];
   logic [15:0] sat_cnt_d [CHANNELS];
`endif

   // Rescale and clamp the stage-1 products.
   always_comb begin
      clamp_sat_s  = '0;
      clamp_data_s = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         scaled_s[c] = rescale(s1_prod_q[c]);
         if (scaled_s[c] > OUT_MAX) begin
            clamp_sat_s[c] = 1'b1;
            clamp_data_s[c*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
         end else if (scaled_s[c] < OUT_MIN) begin
            clamp_sat_s[c] = 1'b1;
            clamp_data_s[c*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
         end else begin
            clamp_sat_s[c] = 1'b0;
            clamp_data_s[c*OUT_WIDTH +: OUT_WIDTH] = scaled_s[c][OUT_WIDTH-1:0];
         end
      end
   end

   // Handshake, gain table, pipeline stages and saturation bookkeeping.
   always_comb begin
      s2_load_s   = !out_valid_q || out_ready;
      in_ready_s  = !s1_valid_q || s2_load_s;
      in_fire_s   = in_valid && in_ready_s;
      gain_d      = gain_q;
      s1_prod_d   = s1_prod_q;
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sat_flag_d  = sat_flag_q;
      sat_set_s   = '0;

      if (gain_wr_en && ({{(32-CH_W){1'b0}}, gain_wr_ch} < CHANNELS_U)) begin
         gain_d[gain_wr_ch] = gain_wr_data;
      end else begin
         gain_d = gain_q;
      end

      // The old gain applies to a beat captured on the same edge as a write.
      if (in_fire_s) begin
         s1_valid_d = 1'b1;
         for (int c = 0; c < CHANNELS; c++) begin
            s1_prod_d[c] = mul_ext(in_data[c*DATA_WIDTH +: DATA_WIDTH], gain_q[c]);
         end
      end else if (s2_load_s) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end

      if (s2_load_s) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = clamp_data_s;
            sat_set_s  = clamp_sat_s;
         end else begin
            out_data_d = out_data_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end

      if (sat_clear) begin
         sat_flag_d = sat_set_s;
      end else begin
         sat_flag_d = sat_flag_q | sat_set_s;
      end

`ifdef SAT_COUNT_EN
      for (int c = 0; c < CHANNELS; c++) begin
         if (sat_clear) begin
            sat_cnt_d[c] = sat_set_s[c] ? 16'd1 : 16'd0;
         end else if (sat_set_s[c] && (sat_cnt_q[c] != CNT_MAX)) begin
            sat_cnt_d[c] = sat_cnt_q[c] + 16'd1;
         end else begin
            sat_cnt_d[c] = sat_cnt_q[c];
         end
      end
`endif
   end

   // State registers; reset discards in-flight beats and restores default gains.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            gain_q[c]    <= GAIN_RST;
            s1_prod_q[c] <= '0;
`ifdef SAT_COUNT_EN
            sat_cnt_q[c] <= 16'd0;
`endif
         end
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_flag_q  <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            gain_q[c]    <= gain_d[c];
            s1_prod_q[c] <= s1_prod_d[c];
`ifdef SAT_COUNT_EN
            sat_cnt_q[c] <= sat_cnt_d[c];
`endif
         end
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sat_flag_q  <= sat_flag_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sat_flag  = sat_flag_q;

`ifdef SAT_COUNT_EN
   for (genvar c = 0; c < CHANNELS; c++) begin : g_sat_count
      assign sat_count[c*16 +: 16] = sat_cnt_q[c];
   end
`endif

endmodule

// File: tb/tb_gain_requant_pipe.sv
// Directed bench for gain_requant_pipe: a default instance (truncate, 32-bit out) and a
// round-half-away, 16-bit-output instance share all stimulus.
module tb_gain_requant_pipe;

   logic        clock = 1'b0;
   logic        reset;
   logic        gain_wr_en;
   logic [0:0]  gain_wr_ch;
   logic [31:0] gain_wr_data;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;
   logic        sat_clear;
   logic        in_ready0, in_ready1, out_valid0, out_valid1;
   logic [63:0] out_data0;
   logic [31:0] out_data1;
   logic [1:0]  sat_flag0, sat_flag1;
`ifdef SAT_COUNT_EN
   logic [31:0] sat_count0, sat_count1;
`endif

   int checks = 0;
   int errors = 0;

   wire signed [31:0] d0_l0 = out_data0[31:0];
   wire signed [31:0] d0_l1 = out_data0[63:32];
   wire signed [15:0] d1_l0 = out_data1[15:0];
   wire signed [15:0] d1_l1 = out_data1[31:16];

   always #5 clock = ~clock;

   gain_requant_pipe dut0 (
      .clock(clock), .reset(reset), .gain_wr_en(gain_wr_en), .gain_wr_ch(gain_wr_ch),
      .gain_wr_data(gain_wr_data), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .sat_flag(sat_flag0),
      .sat_clear(sat_clear)
`ifdef SAT_COUNT_EN
      , .sat_count(sat_count0)
`endif
   );

   gain_requant_pipe #(.ROUND_MODE(1), .OUT_WIDTH(16)) dut1 (
      .clock(clock), .reset(reset), .gain_wr_en(gain_wr_en), .gain_wr_ch(gain_wr_ch),
      .gain_wr_data(gain_wr_data), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .sat_flag(sat_flag1),
      .sat_clear(sat_clear)
`ifdef SAT_COUNT_EN
      , .sat_count(sat_count1)
`endif
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic put(input int a0, input int a1);
      in_data = {a1, a0};
   endtask

   task automatic write_gain(input logic ch, input int g);
      gain_wr_en   = 1'b1;
      gain_wr_ch   = ch;
      gain_wr_data = g;
      tick();
      gain_wr_en   = 1'b0;
   endtask

   task automatic send(input int a0, input int a1);
      in_valid = 1'b1;
      put(a0, a1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; gain_wr_en = 1'b0; gain_wr_ch = 1'b0; gain_wr_data = 32'd0;
      in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b1; sat_clear = 1'b0;
      tick(); tick();
      checks++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b/%b expected 0/0", out_valid0, out_valid1);
      end
      checks++;
      if (out_data0 !== 64'd0 || out_data1 !== 32'd0) begin
         errors++; $display("FAIL reset_out_data: got %h/%h expected 0", out_data0, out_data1);
      end
      checks++;
      if (sat_flag0 !== 2'b00 || sat_flag1 !== 2'b00) begin
         errors++; $display("FAIL reset_sat_flag: got %b/%b expected 00", sat_flag0, sat_flag1);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready0, in_ready1);
      end
   endtask

   task automatic test_passthrough();
      send(5000, -5000);
      checks++;
      if (out_valid0 !== 1'b0) begin
         errors++; $display("FAIL pass_latency_early: got out_valid %b expected 0", out_valid0);
      end
      tick();
      checks++;
      if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin
         errors++; $display("FAIL pass_latency: got %b/%b expected 1/1", out_valid0, out_valid1);
      end
      checks++;
      if (d0_l0 !== 32'sd5000 || d0_l1 !== -32'sd5000) begin
         errors++; $display("FAIL pass_data0: got %0d/%0d expected 5000/-5000", d0_l0, d0_l1);
      end
      checks++;
      if (d1_l0 !== 16'sd5000 || d1_l1 !== -16'sd5000) begin
         errors++; $display("FAIL pass_data1: got %0d/%0d expected 5000/-5000", d1_l0, d1_l1);
      end
      tick();
      checks++;
      if (out_valid0 !== 1'b0) begin
         errors++; $display("FAIL pass_single_beat: got out_valid %b expected 0", out_valid0);
      end
   endtask

   task automatic test_rounding();
      write_gain(1'b0, 1);
      write_gain(1'b1, 1);
      send(-1536, 1536);
      tick();
      checks++;
      if (d0_l0 !== -32'sd1 || d0_l1 !== 32'sd1) begin
         errors++; $display("FAIL round_trunc_1536: got %0d/%0d expected -1/1", d0_l0, d0_l1);
      end
      checks++;
      if (d1_l0 !== -16'sd2 || d1_l1 !== 16'sd2) begin
         errors++; $display("FAIL round_half_1536: got %0d/%0d expected -2/2", d1_l0, d1_l1);
      end
      send(-512, 511);
      tick();
      checks++;
      if (d0_l0 !== 32'sd0 || d0_l1 !== 32'sd0) begin
         errors++; $display("FAIL round_trunc_512: got %0d/%0d expected 0/0", d0_l0, d0_l1);
      end
      checks++;
      if (d1_l0 !== -16'sd1 || d1_l1 !== 16'sd0) begin
         errors++; $display("FAIL round_half_512: got %0d/%0d expected -1/0", d1_l0, d1_l1);
      end
      tick();
   endtask

   task automatic test_saturation();
      write_gain(1'b0, 1024);
      write_gain(1'b1, 1024);
      send(40000, -40000);
      tick();
      checks++;
      if (d1_l0 !== 16'sd32767 || d1_l1 !== -16'sd32768) begin
         errors++; $display("FAIL sat_clamp16: got %0d/%0d expected 32767/-32768", d1_l0, d1_l1);
      end
      checks++;
      if (d0_l0 !== 32'sd40000 || d0_l1 !== -32'sd40000) begin
         errors++; $display("FAIL sat_noclamp32: got %0d/%0d expected 40000/-40000", d0_l0, d0_l1);
      end
      checks++;
      if (sat_flag1 !== 2'b11 || sat_flag0 !== 2'b00) begin
         errors++; $display("FAIL sat_flag_set: got %b/%b expected 00/11", sat_flag0, sat_flag1);
      end
      send(40000, -40000);
      tick();
`ifdef SAT_COUNT_EN
      checks++;
      if (sat_count1 !== {16'd2, 16'd2} || sat_count0 !== 32'd0) begin
         errors++; $display("FAIL sat_count: got %h/%h expected 0/00020002", sat_count0, sat_count1);
      end
`endif
      sat_clear = 1'b1;
      tick();
      sat_clear = 1'b0;
      checks++;
      if (sat_flag1 !== 2'b00) begin
         errors++; $display("FAIL sat_clear: got %b expected 00", sat_flag1);
      end
`ifdef SAT_COUNT_EN
      checks++;
      if (sat_count1 !== 32'd0) begin
         errors++; $display("FAIL sat_count_clear: got %h expected 0", sat_count1);
      end
`endif
      // Clear asserted on the very edge the saturating beat loads: set must win.
      send(40000, 0);
      sat_clear = 1'b1;
      tick();
      sat_clear = 1'b0;
      checks++;
      if (sat_flag1 !== 2'b01) begin
         errors++; $display("FAIL sat_set_wins: got %b expected 01", sat_flag1);
      end
      sat_clear = 1'b1;
      tick();
      sat_clear = 1'b0;
   endtask

   task automatic test_gain_update();
      in_valid = 1'b1;
      put(100, 100);
      gain_wr_en = 1'b1; gain_wr_ch = 1'b0; gain_wr_data = 32'd2048;
      tick();
      gain_wr_en = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid0 !== 1'b1 || d0_l0 !== 32'sd100 || d1_l0 !== 16'sd100) begin
         errors++; $display("FAIL gain_old_beat: got %0d/%0d expected 100/100", d0_l0, d1_l0);
      end
      tick();
      checks++;
      if (out_valid0 !== 1'b1 || d0_l0 !== 32'sd200 || d1_l0 !== 16'sd200) begin
         errors++; $display("FAIL gain_new_beat: got %0d/%0d expected 200/200", d0_l0, d1_l0);
      end
      checks++;
      if (d0_l1 !== 32'sd100) begin
         errors++; $display("FAIL gain_other_lane: got %0d expected 100", d0_l1);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int v, nacc, nrecv;
      logic fire_in;
      int recv0 [5];
      int recv1 [5];
      write_gain(1'b0, 1024);
      v = 1; nacc = 0; nrecv = 0;
      in_valid = 1'b1;
      put(v, v);
      for (int cyc = 0; cyc < 60 && nrecv < 5; cyc++) begin
         out_ready = (cyc >= 6);
         #1;
         if (cyc >= 2 && cyc <= 5) begin
            checks++;
            if (out_valid0 !== 1'b1 || d0_l0 !== 32'sd1) begin
               errors++; $display("FAIL bp_hold: cycle %0d got valid %b data %0d expected 1/1", cyc, out_valid0, d0_l0);
            end
         end
         if (cyc == 5) begin
            checks++;
            if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0 || nacc != 2) begin
               errors++; $display("FAIL bp_in_ready: got ready %b accepted %0d expected 0/2", in_ready0, nacc);
            end
         end
         if (out_valid0 && out_ready) begin
            if (nrecv < 5) begin
               recv0[nrecv] = d0_l0;
               recv1[nrecv] = int'(d1_l0);
            end
            nrecv++;
         end
         fire_in = in_valid && in_ready0;
         tick();
         if (fire_in) begin
            nacc++;
            v++;
            if (v > 5) in_valid = 1'b0;
            else put(v, v);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (nrecv != 5) begin
         errors++; $display("FAIL bp_count: got %0d beats expected 5", nrecv);
      end
      for (int i = 0; i < 5 && i < nrecv; i++) begin
         checks++;
         if (recv0[i] != i + 1 || recv1[i] != i + 1) begin
            errors++; $display("FAIL bp_order: beat %0d got %0d/%0d expected %0d", i, recv0[i], recv1[i], i + 1);
         end
      end
      tick();
      checks++;
      if (out_valid0 !== 1'b0) begin
         errors++; $display("FAIL bp_no_dup: got out_valid %b expected 0", out_valid0);
      end
   endtask

   task automatic test_reset_midflight();
      int stale;
      write_gain(1'b0, 2048);
      out_ready = 1'b0;
      send(9, 9);
      send(10, 10);
      checks++;
      if (out_valid0 !== 1'b1) begin
         errors++; $display("FAIL mf_inflight: got out_valid %b expected 1", out_valid0);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
         errors++; $display("FAIL mf_async: got %b/%b expected 0/0", out_valid0, out_valid1);
      end
      tick(); tick();
      reset = 1'b0;
      out_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid0 || out_valid1) stale++;
      end
      checks++;
      if (stale != 0) begin
         errors++; $display("FAIL mf_stale: got %0d valid cycles expected 0", stale);
      end
      send(7, 7);
      tick();
      checks++;
      if (out_valid0 !== 1'b1 || d0_l0 !== 32'sd7 || d1_l0 !== 16'sd7) begin
         errors++; $display("FAIL mf_gain_default: got %b %0d/%0d expected 1 7/7", out_valid0, d0_l0, d1_l0);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_rounding();
      test_saturation();
      test_gain_update();
      test_back_to_back();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule

// File: doc/gain_requant_pipe.md
Name: gain_requant_pipe

Overview:
Streaming multi-channel fixed-point gain and requantization stage for the FM receive chain: demod gain, volume and de-emphasis scaling. Each channel sample is multiplied by a runtime-loadable per-channel Q-format gain, rescaled by FRAC_BITS with selectable rounding, and saturated to the output width. It is a 2-stage valid/ready pipeline that sits between the demodulator or IIR outputs and the audio decimator.

Parameters:
DATA_WIDTH, 32, signed input sample width per channel
GAIN_WIDTH, 32, signed gain width; gain is Q(GAIN_WIDTH-FRAC_BITS).FRAC_BITS
FRAC_BITS, 10, fractional bits removed after the multiply (1.0 = 1024)
OUT_WIDTH, 32, signed output width per channel
CHANNELS, 2, independent lanes sharing one handshake
ROUND_MODE, 0, 0 = truncate toward zero (integer-divide semantics); 1 = round half away from zero
DEFAULT_GAIN, 1024, reset value of every gain register

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
gain_wr_en  in  1  write strobe for a gain register
gain_wr_ch  in  $clog2(CHANNELS) (min 1)  target channel of the write
gain_wr_data  in  GAIN_WIDTH  new signed gain value
in_valid  in  1  input beat valid
in_ready  out  1  block can accept an input beat
in_data  in  CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_data  out  CHANNELS*OUT_WIDTH  same packing as in_data
sat_flag  out  CHANNELS  sticky per-channel saturation indicator
sat_clear  in  1  clears all sat_flag bits

Behaviour:
- Reset (async assert, sync release): gain[c]=DEFAULT_GAIN, s1_valid=s2_valid=0, out_valid=0, out_data=0, sat_flag=0, in_ready=1 on the first clock after release.
- Stage 1: on in_valid&&in_ready, capture the full-width product in_data[c]*gain[c] (DATA_WIDTH+GAIN_WIDTH signed bits) and set s1_valid.
- Stage 2: rescale the product by 2^FRAC_BITS. ROUND_MODE 0: truncate toward zero (negative values are biased by 2^FRAC_BITS-1 before the arithmetic shift). ROUND_MODE 1: add 2^(FRAC_BITS-1) to the magnitude, then shift, then restore the sign. Clamp the result to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and register it as out_data/out_valid.
- Latency: 2 cycles from input acceptance to out_valid when there is no backpressure. Throughput is 1 beat per cycle.
- Handshake: stage 2 loads when !out_valid || out_ready. Stage 1 advances under the same condition or when s1 is empty. in_ready = !s1_valid || stage-2-load. The block holds at most 2 beats in flight. No beat is dropped or duplicated. out_data stays stable while out_valid && !out_ready.
- Gain write: updates gain[gain_wr_ch] at the clock edge. A beat accepted on the same edge uses the old gain. Beats already in stage 1 or 2 are unaffected. An out-of-range channel index is ignored.
- Saturation: a beat that clamps on channel c sets sat_flag[c] when that beat loads into stage 2. sat_clear clears the flags. If clear and set occur on the same edge, set wins.
- Reset mid-operation: in-flight beats are discarded and gains return to DEFAULT_GAIN.

Optional Feature:
SAT_COUNT_EN
- Defined: adds output port sat_count (CHANNELS*16 bits). Each lane has a 16-bit counter that increments per saturated beat and holds at 0xFFFF. sat_clear zeroes the counters. Reset value is 0.
- Undefined: the port and the counters are absent. All other behaviour is identical.

Test Plan:
- Gain 1024, in 5000 / -5000 on ch0/ch1, out_ready=1 -> out_data 5000 / -5000 exactly 2 cycles after acceptance.
- ROUND_MODE=0, gain 1, in -1536 -> -1. ROUND_MODE=1 with the same input -> -2. Input 1536 -> 1 (mode 0) and 2 (mode 1).
- OUT_WIDTH=16, gain 1024, in 40000 -> 32767 with sat_flag[0]=1. In -40000 -> -32768. sat_clear -> flag returns to 0. Under SAT_COUNT_EN, two saturated beats -> sat_count lane = 2.
- Write gain 2048 on the same edge as input 100 -> that beat outputs 100, and the next beat of 100 outputs 200.
- out_ready held low for 6 cycles while inputs 1..5 are offered -> in_ready drops after 2 beats are accepted. On release the outputs are 1..5 in order with no loss.
- Assert reset while 2 beats are in flight -> out_valid=0 immediately, and no stale beat appears after release.
